// File: rtl/lzc_pkg.sv
// Shared types and elaboration helpers for the leading-digit counter / normaliser.
package lzc_pkg;

    typedef enum logic {
        LZC_ZEROS = 1'b0,
        LZC_ONES  = 1'b1
    } lzc_mode_e;

    function automatic int lzc_cw(input int width);
        return $clog2(width);
    endfunction

    function automatic bit lzc_width_ok(input int width);
        return (width == 8) || (width == 16) || (width == 32) ||
               (width == 64) || (width == 128);
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero count and all-zero flag, built recursively from 8-bit leaves.
module lzc_tree
    import lzc_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CW    = lzc_cw(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    cnt,
    output logic             all_zero
);

    if (WIDTH == 8) begin : gen_leaf
        // Highest set bit wins because it is visited last.
        always_comb begin
            cnt = '0;
            for (int i = 0; i < 8; i++) begin
                if (din[i]) cnt = CW'(7 - i);
            end
        end
        assign all_zero = ~|din;
    end else begin : gen_node
        localparam int HW = WIDTH / 2;
        logic [CW-2:0] hi_cnt, lo_cnt;
        logic          hi_all, lo_all;

        lzc_tree #(.WIDTH(HW)) u_hi (.din(din[WIDTH-1:HW]), .cnt(hi_cnt), .all_zero(hi_all));
        lzc_tree #(.WIDTH(HW)) u_lo (.din(din[HW-1:0]),     .cnt(lo_cnt), .all_zero(lo_all));

        // An all-zero subtree reports count 0, so the root does the same.
        always_comb begin
            cnt = '0;
            if (!hi_all)      cnt = {1'b0, hi_cnt};
            else if (!lo_all) cnt = {1'b1, lo_cnt};
        end
        assign all_zero = hi_all & lo_all;
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage valid/ready pipe: S1 holds the operand, S2 holds count, all flag and normalised data.
module lzc_norm_pipe
    import lzc_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int CW    = lzc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_all,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    if (!lzc_width_ok(WIDTH)) begin : gen_bad_width
        $error("lzc_norm_pipe: WIDTH must be 8, 16, 32, 64 or 128");
    end

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    lzc_mode_e        s1_mode_q,  s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [CW-1:0]    s2_cnt_q,   s2_cnt_d;
    logic             s2_all_q,   s2_all_d;
    logic [WIDTH-1:0] s2_norm_q,  s2_norm_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic             s1_adv, s2_adv;
    logic [WIDTH-1:0] tree_in, norm_sh;
    logic [CW-1:0]    tree_cnt;
    logic             tree_all;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Leading ones are counted as leading zeros of the complement.
    assign tree_in = (s1_mode_q == LZC_ONES) ? ~s1_data_q : s1_data_q;

    lzc_tree #(.WIDTH(WIDTH)) u_tree (.din(tree_in), .cnt(tree_cnt), .all_zero(tree_all));

    always_comb begin
        norm_sh = s1_data_q;
        for (int l = 0; l < CW; l++) begin
            if (tree_cnt[l]) norm_sh = norm_sh << (1 << l);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = lzc_mode_e'(in_mode);
                s1_tag_d  = in_tag;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_cnt_d   = s2_cnt_q;
        s2_all_d   = s2_all_q;
        s2_norm_d  = s2_norm_q;
        s2_tag_d   = s2_tag_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_cnt_d  = tree_cnt;
                s2_all_d  = tree_all;
                s2_norm_d = norm_sh;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= LZC_ZEROS;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_cnt_q   <= '0;
            s2_all_q   <= 1'b0;
            s2_norm_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_all_q   <= s2_all_d;
            s2_norm_q  <= s2_norm_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_count = s2_cnt_q;
    assign out_all   = s2_all_q;
    assign out_norm  = s2_norm_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Scoreboard bench: directed 32-bit vectors plus streaming instances at 8, 64 and 128 bits.
module tb_lzc_norm_pipe;
    import lzc_pkg::*;

    localparam int W  = 32;
    localparam int CW = 5;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_mode, out_valid, out_ready, out_all;
    logic [W-1:0]  in_data, out_norm;
    logic [TW-1:0] in_tag, out_tag;
    logic [CW-1:0] out_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lzc_norm_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_all(out_all), .out_norm(out_norm), .out_tag(out_tag)
    );

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          all;
        logic [W-1:0]  norm;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input logic a, input logic [W-1:0] n, input logic [TW-1:0] t);
        exp_t e;
        e.cnt  = CW'(c);
        e.all  = a;
        e.norm = n;
        e.tag  = t;
        return e;
    endfunction

    // Offers one item; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t,
                        input logic push, input exp_t e);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 128'd0, 128'd1);
        else if (push) q.push_back(e);
    endtask

    task automatic check_latency(input string nm);
        @(negedge clk);
        chk({nm, "_not_yet"}, 128'(out_valid), 128'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 128'(out_valid), 128'd1);
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        chk({nm, "_drained"}, 128'(q.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("main_unexpected_out", 128'(out_tag), 128'hFFFF);
            end else begin
                e = q.pop_front();
                chk("main_norm", 128'(out_norm), 128'(e.norm));
                chk("main_cnt_all_tag", 128'({out_count, out_all, out_tag}),
                    128'({e.cnt, e.all, e.tag}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_count", 128'(out_count), 128'd0);
        chk("reset_out_all",   128'(out_all),   128'd0);
        chk("reset_out_norm",  128'(out_norm),  128'd0);
        chk("reset_out_tag",   128'(out_tag),   128'd0);
        chk("reset_in_ready",  128'(in_ready),  128'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Single transaction, empty pipe: visible after the edge following the capture edge.
        send(32'h0001_0000, 1'b0, 4'd1, 1'b1, mk(15, 1'b0, 32'h8000_0000, 4'd1));
        check_latency("t1_latency");
        drain("t1");

        send(32'h0000_0000, 1'b0, 4'd2, 1'b1, mk(0, 1'b1, 32'h0000_0000, 4'd2));
        send(32'hFFFF_FFFF, 1'b1, 4'd3, 1'b1, mk(0, 1'b1, 32'hFFFF_FFFF, 4'd3));
        send(32'hFFF1_2345, 1'b1, 4'd4, 1'b1, mk(12, 1'b0, 32'h1234_5000, 4'd4));
        send(32'h8000_0000, 1'b0, 4'd5, 1'b1, mk(0, 1'b0, 32'h8000_0000, 4'd5));
        send(32'h7FFF_FFFF, 1'b1, 4'd6, 1'b1, mk(0, 1'b0, 32'h7FFF_FFFF, 4'd6));
        send(32'h0000_0001, 1'b0, 4'd7, 1'b1, mk(31, 1'b0, 32'h8000_0000, 4'd7));
        send(32'hFFFF_FFFE, 1'b1, 4'd8, 1'b1, mk(31, 1'b0, 32'h0000_0000, 4'd8));
        send(32'h0000_00FF, 1'b0, 4'd9, 1'b1, mk(24, 1'b0, 32'hFF00_0000, 4'd9));
        drain("directed");

        // Backpressure: four back-to-back offers against a six-cycle stall.
        out_ready = 1'b0;
        fork
            begin
                send(32'h00F0_0000, 1'b0, 4'd1, 1'b1, mk(8,  1'b0, 32'hF000_0000, 4'd1));
                send(32'h0000_0100, 1'b0, 4'd2, 1'b1, mk(23, 1'b0, 32'h8000_0000, 4'd2));
                send(32'h1000_0000, 1'b0, 4'd3, 1'b1, mk(3,  1'b0, 32'h8000_0000, 4'd3));
                send(32'hC000_0000, 1'b1, 4'd4, 1'b1, mk(2,  1'b0, 32'h0000_0000, 4'd4));
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (k == 1) chk("bp_in_ready_low", 128'(in_ready), 128'd0);
                    if (k >= 1) begin
                        chk("bp_stall_valid", 128'(out_valid), 128'd1);
                        chk("bp_stall_tag",   128'(out_tag),   128'd1);
                        chk("bp_stall_norm",  128'(out_norm),  128'hF000_0000);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(32'h0000_0F00, 1'b0, 4'd10, 1'b0, mk(0, 1'b0, '0, '0));
        send(32'h0F00_0000, 1'b0, 4'd11, 1'b0, mk(0, 1'b0, '0, '0));
        @(negedge clk);
        chk("pre_reset_full", 128'({out_valid, in_ready}), 128'b10);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out_count", 128'(out_count), 128'd0);
        chk("midrst_out_all",   128'(out_all),   128'd0);
        chk("midrst_out_norm",  128'(out_norm),  128'd0);
        chk("midrst_out_tag",   128'(out_tag),   128'd0);
        chk("midrst_in_ready",  128'(in_ready),  128'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(32'h0000_8000, 1'b0, 4'd12, 1'b1, mk(16, 1'b0, 32'h8000_0000, 4'd12));
        check_latency("post_reset_latency");
        drain("post_reset");

        wait (gen_w[0].done_w && gen_w[1].done_w && gen_w[2].done_w);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Streaming instances with random out_ready against a bit-serial reference model.
    for (genvar g = 0; g < 3; g++) begin : gen_w
        localparam int GW  = (g == 0) ? 8 : (g == 1) ? 64 : 128;
        localparam int GCW = $clog2(GW);

        typedef struct packed {
            logic [GCW-1:0] cnt;
            logic           all;
            logic [GW-1:0]  norm;
            logic [3:0]     tag;
        } gexp_t;

        logic           g_rst, g_iv, g_ir, g_im, g_ov, g_or, g_all;
        logic [GW-1:0]  g_id, g_norm;
        logic [GCW-1:0] g_cnt;
        logic [3:0]     g_it, g_ot;
        bit             done_w = 1'b0;
        gexp_t          gq[$];

        lzc_norm_pipe #(.WIDTH(GW), .TAG_W(4)) u_dut (
            .clk(clk), .rst(g_rst),
            .in_valid(g_iv), .in_ready(g_ir), .in_data(g_id),
            .in_mode(g_im), .in_tag(g_it),
            .out_valid(g_ov), .out_ready(g_or), .out_count(g_cnt),
            .out_all(g_all), .out_norm(g_norm), .out_tag(g_ot)
        );

        function automatic gexp_t model(input logic [GW-1:0] d, input logic m, input logic [3:0] t);
            gexp_t         e;
            logic [GW-1:0] x;
            int            n;
            x = m ? ~d : d;
            n = 0;
            while (n < GW && !x[GW-1-n]) n++;
            e.tag  = t;
            e.all  = (n == GW);
            e.cnt  = e.all ? '0 : GCW'(n);
            e.norm = e.all ? d : (d << n);
            return e;
        endfunction

        task automatic gsend(input logic [GW-1:0] d, input logic m, input logic [3:0] t, input gexp_t e);
            logic acc;
            acc  = 1'b0;
            g_iv = 1'b1;
            g_id = d;
            g_im = m;
            g_it = t;
            for (int k = 0; k < 100 && !acc; k++) begin
                @(negedge clk);
                acc = g_ir;
                @(posedge clk);
                #1;
            end
            g_iv = 1'b0;
            if (!acc) chk($sformatf("w%0d_send_timeout", GW), 128'd0, 128'd1);
            else gq.push_back(e);
        endtask

        always begin
            @(posedge clk);
            #1 g_or = ($urandom_range(3) != 0);
        end

        always @(negedge clk) begin
            if (!g_rst && g_ov && g_or) begin
                gexp_t e;
                if (gq.size() == 0) begin
                    chk($sformatf("w%0d_unexpected_out", GW), 128'(g_ot), 128'hFFFF);
                end else begin
                    e = gq.pop_front();
                    chk($sformatf("w%0d_norm", GW), 128'(g_norm), 128'(e.norm));
                    chk($sformatf("w%0d_cnt_all_tag", GW), 128'({g_cnt, g_all, g_ot}),
                        128'({e.cnt, e.all, e.tag}));
                end
            end
        end

        initial begin
            logic [GW-1:0] d, one;
            logic          m;
            gexp_t         e;
            int            k;
            g_rst = 1'b1; g_iv = 1'b0; g_id = '0; g_im = 1'b0; g_it = '0; g_or = 1'b1;
            repeat (2) @(posedge clk);
            #1 g_rst = 1'b0;

            // Only the LSB set: count is GW-1 and the bit lands in the MSB.
            one    = '0;
            one[0] = 1'b1;
            e.cnt  = GCW'(GW - 1);
            e.all  = 1'b0;
            e.norm = '0;
            e.norm[GW-1] = 1'b1;
            e.tag  = 4'hA;
            gsend(one, 1'b0, 4'hA, e);
            e.cnt = '0; e.all = 1'b1; e.norm = '0; e.tag = 4'hB;
            gsend('0, 1'b0, 4'hB, e);

            for (int i = 0; i < 300; i++) begin
                for (int b = 0; b < GW; b++) d[b] = 1'($urandom_range(1));
                d = d >> $urandom_range(GW);
                m = 1'($urandom_range(1));
                if (m) d = ~d;
                gsend(d, m, 4'(i), model(d, m, 4'(i)));
            end

            k = 0;
            while (gq.size() != 0 && k < 2000) begin
                @(posedge clk);
                k++;
            end
            #1;
            chk($sformatf("w%0d_drained", GW), 128'(gq.size()), 128'd0);
            done_w = 1'b1;
        end
    end

endmodule
